// File: rtl/stdout_uart_pkg.sv
// Shared definitions for the stdout UART: TX state encoding and default sizing.
package stdout_uart_pkg;

   localparam int DEF_CLKS_PER_BIT = 868;   // 115200 baud from a 100 MHz clock
   localparam int DEF_FIFO_DEPTH   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/stdout_uart_byte_fifo.sv
// Power-of-two byte FIFO; a push into a full FIFO is ignored even if a pop happens that cycle.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/stdout_uart.sv
// Byte-wide stdout capture into a FIFO, serialised as 8N1 UART frames on txd.
//
// state | meaning
// IDLE  | line high; pops the FIFO head into the shifter when data is waiting
// START | start bit, txd low for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit, txd high for CLKS_PER_BIT cycles
module stdout_uart
   import stdout_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wdata,
   input  logic       we,
   output logic       full,
   output logic       overflow,
   output logic       busy,
   output logic       txd
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   tx_state_e     state;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    fifo_dout;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          pop;
   logic          baud_tc;

   assign pop     = (state == IDLE) && !fifo_empty;
   assign baud_tc = (baud_cnt == BAUD_LAST);
   assign busy    = (fifo_count != '0) || (state != IDLE);

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (we),
      .din   (wdata),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (we && full) begin
         overflow <= 1'b1;
      end
   end

   // txd follows the state one cycle later, giving the push-to-start-bit latency of two edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         txd <= 1'b1;
      end else begin
         unique case (state)
            START:   txd <= 1'b0;
            DATA:    txd <= shift[0];
            default: txd <= 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (pop) begin
                  shift <= fifo_dout;
                  state <= START;
               end
            end
            START: begin
               if (baud_tc) begin
                  baud_cnt <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_tc) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_tc) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
